// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: one RAM byte per clock, little-endian, sign/zero-extended loads.
// Optional misalignment rejection is enabled by defining LSU_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module lsu_byte_serial #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_DRAIN, S_ERR, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, nbytes;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_d;
  logic [31:0]       wdata_q, wdata_d, data_q, data_d, full, ext, resp_rdata_d;
  logic              write_q, write_d, unsigned_q, unsigned_d;
  logic [1:0]        width_q, width_d;
  logic              req_ready_d, resp_valid_d, resp_err_d, mem_we_d, bad_req;
  logic [7:0]        mem_wdata_d;

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      width_q    <= '0;
      unsigned_q <= 1'b0;
      data_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      width_q    <= width_d;
      unsigned_q <= unsigned_d;
      data_q     <= data_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    width_d      = width_q;
    unsigned_d   = unsigned_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata;
    mem_addr_d   = mem_addr;
    mem_we_d     = 1'b0;
    mem_wdata_d  = '0;
    full         = data_q;
    ext          = '0;

    case (width_q)
      2'b00:   nbytes = IDX_W'(1);
      2'b01:   nbytes = IDX_W'(2);
      default: nbytes = IDX_W'(4);
    endcase

    bad_req = (req_width == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if (req_width == 2'b01 && req_addr[0])          bad_req = 1'b1;
    if (req_width == 2'b10 && req_addr[1:0] != 2'b00) bad_req = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          write_d    = req_write;
          width_d    = req_width;
          unsigned_d = req_unsigned;
          data_d     = '0;
          if (bad_req) begin
            state_d = S_ERR;
          end else begin
            state_d     = S_ACCESS;
            idx_d       = IDX_W'(1);
            mem_addr_d  = req_addr;
            mem_we_d    = req_write;
            mem_wdata_d = req_write ? req_wdata[7:0] : 8'h00;
          end
        end
      end
      S_ACCESS: begin
        // Read data lags its address by two edges: byte idx-2 is on mem_rdata now
        if (idx_q >= IDX_W'(2)) begin
          for (int b = 0; b < 4; b++)
            if (IDX_W'(b) == idx_q - IDX_W'(2)) data_d[8*b +: 8] = mem_rdata;
        end
        if (idx_q == nbytes) begin
          if (write_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          mem_addr_d = addr_q + ADDR_W'(idx_q);
          mem_we_d   = write_q;
          if (write_q) begin
            for (int b = 0; b < 4; b++)
              if (IDX_W'(b) == idx_q) mem_wdata_d = wdata_q[8*b +: 8];
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        for (int b = 0; b < 4; b++)
          if (IDX_W'(b) == nbytes - IDX_W'(1)) full[8*b +: 8] = mem_rdata;
        case (width_q)
          2'b00:   ext = {(unsigned_q ? 24'h0 : {24{full[7]}}), full[7:0]};
          2'b01:   ext = {(unsigned_q ? 16'h0 : {16{full[15]}}), full[15:0]};
          default: ext = full;
        endcase
        data_d       = full;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ext;
      end
      S_ERR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial: a byte-addressed RAM model, a request-level
// expectation model, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_lsu_byte_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  lsu_byte_serial #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  // Expectation for the request in flight
  logic        busy = 1'b0, quiet = 1'b0;
  int          acc_cyc = 0, e_n = 0, e_l = 0;
  logic        e_w = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  function automatic logic [7:0] grd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rrd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [7:0] v);
    ram[a]  = v;
    gold[a] = v;
  endtask

  // Synchronous byte RAM: read data appears one cycle after the address
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    mem_rdata <= rrd(mem_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the request-level expectation
  always @(negedge clk) begin
    int k;
    if (rst_n && !quiet) begin
      k = cyc - acc_cyc;
      if (!busy || k < 0) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'(k == e_l));
        if (k == e_l) begin
          chk("resp_err", 32'(resp_err), 32'(e_err));
          chk("resp_rdata", resp_rdata, e_rdata);
          last_rdata = resp_rdata;
          last_err   = resp_err;
        end
        chk("mem_we", 32'(mem_we), 32'(e_w && !e_err && k < e_n));
        if (!e_err && k < e_n) begin
          chk("mem_addr", mem_addr, e_addr + 32'(k));
          if (e_w) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata[8*k +: 8]));
        end
        chk("req_ready", 32'(req_ready), 32'(k > e_l));
        if (k > e_l) busy = 1'b0;
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] wd, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    logic err;
    logic [31:0] val;
    n   = (wd == 2'b00) ? 1 : (wd == 2'b01) ? 2 : 4;
    err = (wd == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
    if ((wd == 2'b01 && a[0]) || (wd == 2'b10 && a[1:0] != 2'b00)) err = 1'b1;
`endif
    val = '0;
    if (!err && !w) begin
      for (int i = 0; i < n; i++) val |= 32'(grd(a + 32'(i))) << (8 * i);
      if (!u && n < 4 && val[8*n-1]) val |= ~((32'h1 << (8 * n)) - 32'h1);
    end
    if (!err && w)
      for (int i = 0; i < n; i++) gold[a + 32'(i)] = d[8*i +: 8];
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_width = wd; req_unsigned = u;
    req_addr = a; req_wdata = d;
    e_w = w; e_err = err; e_n = err ? 0 : n;
    e_l = err ? 1 : (w ? n : n + 1);
    e_addr = a; e_wdata = d; e_rdata = val;
    acc_cyc = cyc + 1;
    busy = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the request after accept; the unit must have captured it
    req_valid = 1'b0; req_write = ~w; req_width = ~wd; req_unsigned = ~u;
    req_addr = $urandom; req_wdata = $urandom;
    for (int t = 0; t < 30 && busy; t++) @(negedge clk);
    if (busy) begin
      vectors++; errs++;
      $display("FAIL timeout: response not seen for addr %h", a);
      busy = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_width = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    put(32'h80, 8'h58); put(32'h81, 8'h00); put(32'h82, 8'h00); put(32'h83, 8'h00);
    put(32'h10, 8'hF0);
    put(32'h78, 8'hA5); put(32'h7D, 8'h5A);
    put(32'hFFFFFFFF, 8'h34); put(32'h0, 8'h92);
    put(32'h200, 8'h11); put(32'h201, 8'h22); put(32'h202, 8'h33); put(32'h203, 8'h44);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    chk("lw80_lit", last_rdata, 32'h00000058);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("lb10_lit", last_rdata, 32'hFFFFFFF0);
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lbu10_lit", last_rdata, 32'h000000F0);

    issue(1'b1, 2'b10, 1'b0, 32'h79, 32'h12345678);
`ifndef LSU_ALIGN_CHECK_EN
    chk("sw79_b0", 32'(rrd(32'h79)), 32'h78);
    chk("sw79_b1", 32'(rrd(32'h7A)), 32'h56);
    chk("sw79_b2", 32'(rrd(32'h7B)), 32'h34);
    chk("sw79_b3", 32'(rrd(32'h7C)), 32'h12);
`endif
    chk("sw79_below", 32'(rrd(32'h78)), 32'hA5);
    chk("sw79_above", 32'(rrd(32'h7D)), 32'h5A);
    issue(1'b0, 2'b10, 1'b0, 32'h79, 32'h0);

    issue(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lh_wrap_err", 32'(last_err), 32'd1);
`else
    chk("lh_wrap_lit", last_rdata, 32'hFFFF9234);
`endif
    issue(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'h0);

    issue(1'b0, 2'b11, 1'b0, 32'h80, 32'h0);
    chk("w11_err", 32'(last_err), 32'd1);
    chk("w11_rdata", last_rdata, 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h80, 32'hDEADBEEF);
    chk("w11_noaccess", 32'(rrd(32'h80)), 32'h58);

    issue(1'b1, 2'b01, 1'b0, 32'h40, 32'h0000BEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
    chk("lh40_lit", last_rdata, 32'hFFFFBEEF);
    issue(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
    chk("lhu40_lit", last_rdata, 32'h0000BEEF);
    issue(1'b1, 2'b00, 1'b0, 32'h42, 32'hFFFFFF7F);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("lw40_lit", last_rdata, 32'h007FBEEF);

    // Reset during the third byte of a word store
    quiet = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_addr", mem_addr, 32'h202);
    chk("mid_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", 32'(mem_we), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_b0", 32'(rrd(32'h200)), 32'hDD);
    chk("rst_b1", 32'(rrd(32'h201)), 32'hCC);
    chk("rst_b2", 32'(rrd(32'h202)), 32'h33);
    chk("rst_b3", 32'(rrd(32'h203)), 32'h44);
    gold[32'h200] = 8'hDD; gold[32'h201] = 8'hCC;
    quiet = 1'b0;

    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    chk("lw200_lit", last_rdata, 32'h4433CCDD);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
